// File: rtl/sm_clk_gen.sv
// sm_clk_gen: programmable CPU clock generator with synchronised, debounced board inputs.
// Modes HALT / RUN / STEP / BURST; define SM_CLK_GEN_CYCLE_CNT_EN to build the cycleCnt counter.
module sm_clk_gen #(
    parameter int CNT_W       = 32,
    parameter int SHIFT       = 16,
    parameter int DIV_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 1024,
    parameter int BURST_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIV_W-1:0]   divide,
    input  logic [1:0]         mode,
    input  logic               stepBtn,
    input  logic [BURST_W-1:0] runCount,
    output logic               clkOut,
    output logic               clkEn,
    output logic               running,
    output logic [31:0]        cycleCnt
);
    localparam int IW = (CNT_W > 1) ? $clog2(CNT_W) : 1;
    localparam int DW = $clog2(DEB_CYCLES);

    localparam logic [2:0] ST_HALT  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_STEP  = 3'd2;
    localparam logic [2:0] ST_BIDLE = 3'd3;
    localparam logic [2:0] ST_BRUN  = 3'd4;

    localparam logic [1:0] MODE_HALT  = 2'b00;
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;

    logic [DIV_W-1:0]       div_pipe  [SYNC_STAGES];
    logic [1:0]             mode_pipe [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] btn_pipe;

    logic [DIV_W-1:0] div_sync;
    logic [1:0]       mode_sync;
    logic             btn_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                div_pipe[i]  <= '0;
                mode_pipe[i] <= '0;
            end
            btn_pipe <= '0;
        end else begin
            div_pipe[0]  <= divide;
            mode_pipe[0] <= mode;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                div_pipe[i]  <= div_pipe[i-1];
                mode_pipe[i] <= mode_pipe[i-1];
            end
            btn_pipe <= {btn_pipe[SYNC_STAGES-2:0], stepBtn};
        end
    end

    always_comb begin
        div_sync  = div_pipe[SYNC_STAGES-1];
        mode_sync = mode_pipe[SYNC_STAGES-1];
        btn_sync  = btn_pipe[SYNC_STAGES-1];
    end

    // Debouncer: btn_stable follows btn_sync only after DEB_CYCLES consecutive disagreeing cycles.
    logic [DW-1:0] deb_cnt;
    logic          btn_stable;
    logic          step_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt    <= '0;
            btn_stable <= 1'b0;
            step_req   <= 1'b0;
        end else begin
            step_req <= 1'b0;
            if (btn_sync != btn_stable) begin
                if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
                    btn_stable <= btn_sync;
                    deb_cnt    <= '0;
                    step_req   <= btn_sync;
                end else begin
                    deb_cnt <= deb_cnt + DW'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    logic [2:0]         state, state_n, entry_state, cur_family;
    logic [CNT_W-1:0]   cntr, cntr_n;
    logic [BURST_W-1:0] remaining, rem_n;
    logic [DIV_W-1:0]   div_prev;
    logic               div_chg;
    logic               en_n, out_n, run_n;

    logic [IW-1:0]    e;
    logic [CNT_W-1:0] mask;
    logic             tick, clk_bit;

    // Exponent 0 gives an empty mask, so tick is then asserted every cycle.
    always_comb begin
        e       = IW'(SHIFT) + IW'(div_sync);
        mask    = (CNT_W'(1) << e) - CNT_W'(1);
        tick    = (cntr & mask) == mask;
        clk_bit = (e == '0) ? tick : cntr[e - IW'(1)];
    end

    always_comb begin
        case (mode_sync)
            MODE_HALT: entry_state = ST_HALT;
            MODE_RUN:  entry_state = ST_RUN;
            MODE_STEP: entry_state = ST_STEP;
            default:   entry_state = ST_BIDLE;
        endcase
        cur_family = (state == ST_BRUN) ? ST_BIDLE : state;
        div_chg    = (div_sync != div_prev);

        state_n = state;
        cntr_n  = cntr;
        rem_n   = remaining;
        en_n    = 1'b0;
        out_n   = 1'b0;
        run_n   = 1'b0;

        // Mode change always wins: everything in flight is dropped without a partial tick.
        if (entry_state != cur_family) begin
            state_n = entry_state;
            cntr_n  = '0;
            rem_n   = '0;
        end else begin
            case (state)
                ST_RUN: begin
                    run_n = 1'b1;
                    if (div_chg) begin
                        cntr_n = '0;
                    end else begin
                        cntr_n = cntr + CNT_W'(1);
                        en_n   = tick;
                        out_n  = clk_bit;
                    end
                end
                ST_STEP: begin
                    cntr_n = '0;
                    if (step_req && !clkEn) begin
                        en_n  = 1'b1;
                        out_n = 1'b1;
                        run_n = 1'b1;
                    end
                end
                ST_BIDLE: begin
                    cntr_n = '0;
                    if (step_req) begin
                        rem_n = runCount;
                        if (runCount != '0) state_n = ST_BRUN;
                    end
                end
                ST_BRUN: begin
                    run_n = 1'b1;
                    if (div_chg) begin
                        cntr_n = '0;
                    end else begin
                        cntr_n = cntr + CNT_W'(1);
                        out_n  = clk_bit;
                        if (tick) begin
                            en_n  = 1'b1;
                            rem_n = remaining - BURST_W'(1);
                            if (remaining == BURST_W'(1)) begin
                                state_n = ST_BIDLE;
                                cntr_n  = '0;
                            end
                        end
                    end
                end
                default: begin
                    state_n = ST_HALT;
                    cntr_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_HALT;
            cntr      <= '0;
            remaining <= '0;
            div_prev  <= '0;
            clkEn     <= 1'b0;
            clkOut    <= 1'b0;
            running   <= 1'b0;
        end else begin
            state     <= state_n;
            cntr      <= cntr_n;
            remaining <= rem_n;
            div_prev  <= div_sync;
            clkEn     <= en_n;
            clkOut    <= out_n;
            running   <= run_n;
        end
    end

`ifdef SM_CLK_GEN_CYCLE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)       cycleCnt <= '0;
        else if (en_n) cycleCnt <= cycleCnt + 32'd1;
    end
`else
    assign cycleCnt = '0;
`endif

endmodule

// File: tb/tb_sm_clk_gen.sv
// Directed self-checking bench for sm_clk_gen (SHIFT=1, DEB_CYCLES=8, SYNC_STAGES=2).
module tb_sm_clk_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  divide;
    logic [1:0]  mode;
    logic        stepBtn;
    logic [15:0] runCount;
    logic        clkOut, clkEn, running;
    logic [31:0] cycleCnt;

`ifdef SM_CLK_GEN_CYCLE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    int          nasserts = 0;
    int          nfail    = 0;
    int unsigned exp_cyc  = 0;
    logic        exp_en, exp_out, exp_run;

    sm_clk_gen #(
        .CNT_W(32), .SHIFT(1), .DIV_W(4), .SYNC_STAGES(2), .DEB_CYCLES(8), .BURST_W(16)
    ) dut (
        .clk(clk), .rst(rst), .divide(divide), .mode(mode), .stepBtn(stepBtn),
        .runCount(runCount), .clkOut(clkOut), .clkEn(clkEn), .running(running),
        .cycleCnt(cycleCnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nasserts++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_cyc(input logic en);
        if (en) exp_cyc++;
        chk("cycleCnt", cycleCnt, CNT_ON ? 32'(exp_cyc) : 32'd0);
    endtask

    initial begin
        rst = 1'b1; divide = '0; mode = 2'b00; stepBtn = 1'b0; runCount = '0;
        repeat (3) tick();
        chk("rst_clkOut", clkOut, 0);
        chk("rst_clkEn", clkEn, 0);
        chk("rst_running", running, 0);
        chk("rst_cycleCnt", cycleCnt, 0);
        rst = 1'b0;

        // RUN with exponent 2: period 4, clkOut 0011
        divide = 4'd1; mode = 2'b01;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("run_sync_en", clkEn, 0);
            chk("run_sync_running", running, 0);
        end
        for (int i = 0; i <= 40; i++) begin
            tick();
            exp_en  = (i % 4) == 3;
            exp_out = (i % 4) >= 2;
            chk("run_en", clkEn, exp_en);
            chk("run_out", clkOut, exp_out);
            chk("run_running", running, 1);
            chk_cyc(exp_en);
        end
        chk("run_cycleCnt_10", cycleCnt, CNT_ON ? 32'd10 : 32'd0);

        // divide change mid-period: exponent 2 -> 3
        divide = 4'd2;
        for (int k = 1; k <= 27; k++) begin
            tick();
            exp_en = (k >= 11) && (((k - 11) % 8) == 0);
            chk("div_chg_en", clkEn, exp_en);
            chk_cyc(exp_en);
        end

        // STEP mode
        mode = 2'b10;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("to_step_en", clkEn, 0);
            if (k >= 3) chk("to_step_running", running, 0);
        end
        stepBtn = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 5) stepBtn = 1'b0;
            chk("glitch_en", clkEn, 0);
            chk_cyc(1'b0);
        end
        stepBtn = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (k == 20) stepBtn = 1'b0;
            exp_en = (k == 11);
            chk("step_en", clkEn, exp_en);
            chk("step_out", clkOut, exp_en);
            chk("step_running", running, exp_en);
            chk_cyc(exp_en);
        end

        // BURST of 3 at period 2
        mode = 2'b11; divide = 4'd0; runCount = 16'd3;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("to_burst_en", clkEn, 0);
        end
        stepBtn = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            tick();
            if (k == 12) stepBtn = 1'b0;
            exp_en  = (k == 13) || (k == 15) || (k == 17);
            exp_run = (k >= 12) && (k <= 17);
            chk("burst_en", clkEn, exp_en);
            chk("burst_out", clkOut, exp_en);
            chk("burst_running", running, exp_run);
            chk_cyc(exp_en);
        end

        // BURST of 3 at period 8, second press lands inside the burst
        divide = 4'd2;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("burst2_settle_en", clkEn, 0);
        end
        stepBtn = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (k == 12) stepBtn = 1'b0;
            if (k == 22) stepBtn = 1'b1;
            if (k == 40) stepBtn = 1'b0;
            exp_en  = (k == 19) || (k == 27) || (k == 35);
            exp_run = (k >= 12) && (k <= 35);
            chk("burst2_en", clkEn, exp_en);
            chk("burst2_running", running, exp_run);
            chk_cyc(exp_en);
        end

        // BURST with runCount 0: a press produces nothing
        runCount = 16'd0;
        stepBtn  = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            tick();
            if (k == 12) stepBtn = 1'b0;
            chk("burst0_en", clkEn, 0);
            chk("burst0_running", running, 0);
            chk_cyc(1'b0);
        end

        // Reset mid-period while running
        mode = 2'b01; divide = 4'd1;
        repeat (10) tick();
        chk("pre_rst_out", clkOut, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_clkOut", clkOut, 0);
        chk("mid_rst_clkEn", clkEn, 0);
        chk("mid_rst_running", running, 0);
        chk("mid_rst_cycleCnt", cycleCnt, 0);
        exp_cyc = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_run = (k >= 4);
            exp_en  = (k >= 4) && (((k - 4) % 4) == 3);
            exp_out = (k >= 4) && (((k - 4) % 4) >= 2);
            chk("post_rst_running", running, exp_run);
            chk("post_rst_en", clkEn, exp_en);
            chk("post_rst_out", clkOut, exp_out);
            chk_cyc(exp_en);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfail);
        $finish;
    end
endmodule
